tcm_port_arbiter: RTL

Two-requester arbiter and sequencer for one port of the dual-port TCM RAM (1-cycle registered read, byte-strobed write, read-first). It accepts valid/ready requests from a data-side port (port 0) and an instruction-side port (port 1), grants at most one per cycle, and drives the RAM port. It returns each response to the requester that issued it, with backpressure absorbed by a per-port response hold slot. Out-of-range addresses are rejected with an error response and never reach the RAM.

---
 rtl/mem_defines.sv | 26 ++
 rtl/tcm_rsp_slot.sv | 89 ++++++++
 rtl/tcm_port_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_defines.sv
// ============================================================================
//  Package     : mem_defines
//  Description : Shared request/response types for the TCM port arbiter.
//  Contents    : TCM_NUM_PORTS constant, tcm_req_t, tcm_rsp_t.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_defines;

   localparam int TCM_NUM_PORTS = 2;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } tcm_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } tcm_rsp_t;

endpackage : mem_defines

`default_nettype wire

// File: rtl/tcm_rsp_slot.sv
// ============================================================================
//  Module      : tcm_rsp_slot
//  Description : Per-port response tracker. Remembers what was granted last
//                cycle (inflight / write / error) and holds the response in a
//                one-entry slot when the requester back-pressures.
//  Ports       : clk_i, rst_n_i        clock, async active-low reset
//                grant_i              port granted this cycle
//                grant_wr_i           granted request is a write
//                grant_err_i          granted request is out of range
//                rsp_ready_i          requester accepts response
//                ram_rdata_i          RAM registered read data
//                eligible_o           port may be granted this cycle
//                rsp_valid_o/rdata_o/err_o  response to requester
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tcm_rsp_slot
   import mem_defines::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        grant_i,
   input  logic        grant_wr_i,
   input  logic        grant_err_i,
   input  logic        rsp_ready_i,
   input  logic [31:0] ram_rdata_i,
   output logic        eligible_o,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   logic     r_inflight;
   logic     r_is_wr;
   logic     r_err;
   logic     r_hold_vld;
   tcm_rsp_t r_hold;
   tcm_rsp_t w_live;

   // Writes and errors never expose RAM data (read-first old word stays hidden).
   always_comb begin
      w_live.rdata = (r_is_wr || r_err) ? 32'h0 : ram_rdata_i;
      w_live.err   = r_err;
   end

   // A draining hold slot keeps the port ineligible for the whole cycle.
   assign eligible_o = ~r_hold_vld & (~r_inflight | rsp_ready_i);

   always_comb begin
      rsp_valid_o = 1'b0;
      rsp_rdata_o = 32'h0;
      rsp_err_o   = 1'b0;
      if (r_hold_vld) begin
         rsp_valid_o = 1'b1;
         rsp_rdata_o = r_hold.rdata;
         rsp_err_o   = r_hold.err;
      end else if (r_inflight) begin
         rsp_valid_o = 1'b1;
         rsp_rdata_o = w_live.rdata;
         rsp_err_o   = w_live.err;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_inflight <= 1'b0;
         r_is_wr    <= 1'b0;
         r_err      <= 1'b0;
         r_hold_vld <= 1'b0;
         r_hold     <= '0;
      end else begin
         r_inflight <= grant_i;
         if (grant_i) begin
            r_is_wr <= grant_wr_i;
            r_err   <= grant_err_i;
         end
         if (r_hold_vld) begin
            if (rsp_ready_i) r_hold_vld <= 1'b0;
         end else if (r_inflight && !rsp_ready_i) begin
            r_hold_vld <= 1'b1;
            r_hold     <= w_live;
         end
      end
   end

endmodule : tcm_rsp_slot

`default_nettype wire

// File: rtl/tcm_port_arbiter.sv
// ============================================================================
//  Module      : tcm_port_arbiter
//  Description : Two-requester arbiter/sequencer for one TCM RAM port.
//                Port 0 = data side, port 1 = instruction side. At most one
//                grant per cycle; responses return 1 cycle after grant, with
//                a per-port hold slot absorbing back-pressure. Out-of-range
//                addresses get an error response and never reach the RAM.
//  Config      : TCM_ARB_FIXED_PRIO_EN defined -> port 0 always wins;
//                undefined -> round-robin.
//  Ports       : clk_i, rst_n_i; reqN_* request channel; rspN_* response
//                channel; ram_* RAM port (1-cycle registered read).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tcm_port_arbiter
   import mem_defines::*;
#(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  req0_valid_i,
   output logic                  req0_ready_o,
   input  logic [31:0]           req0_addr_i,
   input  logic [31:0]           req0_wdata_i,
   input  logic [3:0]            req0_wstrb_i,
   output logic                  rsp0_valid_o,
   input  logic                  rsp0_ready_i,
   output logic [31:0]           rsp0_rdata_o,
   output logic                  rsp0_err_o,
   input  logic                  req1_valid_i,
   output logic                  req1_ready_o,
   input  logic [31:0]           req1_addr_i,
   input  logic [31:0]           req1_wdata_i,
   input  logic [3:0]            req1_wstrb_i,
   output logic                  rsp1_valid_o,
   input  logic                  rsp1_ready_i,
   output logic [31:0]           rsp1_rdata_o,
   output logic                  rsp1_err_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [31:0]           ram_wdata_o,
   output logic [3:0]            ram_wr_o,
   input  logic [31:0]           ram_rdata_i
);

   tcm_req_t              w_req0_s, w_req1_s, w_sel;
   logic                  w_elig0, w_elig1;
   logic                  w_want0, w_want1;
   logic                  w_gnt0, w_gnt1;
   logic                  w_oor0, w_oor1, w_sel_oor;
   logic                  w_ram_go;
   logic [ADDR_WIDTH-1:0] w_sel_word;
   logic [ADDR_WIDTH-1:0] r_ram_addr;
   logic [31:0]           r_ram_wdata;
   logic                  w_unused_addr_lsb;

   assign w_req0_s = '{addr: req0_addr_i, wdata: req0_wdata_i, wstrb: req0_wstrb_i};
   assign w_req1_s = '{addr: req1_addr_i, wdata: req1_wdata_i, wstrb: req1_wstrb_i};

   assign w_oor0 = |req0_addr_i[31:ADDR_WIDTH];
   assign w_oor1 = |req1_addr_i[31:ADDR_WIDTH];

   // Grants are forced low during reset so nothing is accepted or written.
   assign w_want0 = rst_n_i & req0_valid_i & w_elig0;
   assign w_want1 = rst_n_i & req1_valid_i & w_elig1;

`ifdef TCM_ARB_FIXED_PRIO_EN
   assign w_gnt0 = w_want0;
   assign w_gnt1 = w_want1 & ~w_want0;
`else
   // r_last_grant = 1 means port 1 was granted last, so port 0 wins next tie.
   logic r_last_grant;

   assign w_gnt0 = w_want0 & (~w_want1 | r_last_grant);
   assign w_gnt1 = w_want1 & (~w_want0 | ~r_last_grant);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         r_last_grant <= 1'b1;
      else if (w_gnt0 || w_gnt1)
         r_last_grant <= w_gnt1;
   end
`endif

   assign req0_ready_o = w_gnt0;
   assign req1_ready_o = w_gnt1;

   // RAM mux: the selected request only drives the RAM when in range.
   assign w_sel      = w_gnt1 ? w_req1_s : w_req0_s;
   assign w_sel_oor  = w_gnt1 ? w_oor1 : w_oor0;
   assign w_ram_go   = (w_gnt0 | w_gnt1) & ~w_sel_oor;
   assign w_sel_word = {2'b00, w_sel.addr[ADDR_WIDTH-1:2]};
   assign w_unused_addr_lsb = ^w_sel.addr[1:0];

   assign ram_addr_o  = w_ram_go ? w_sel_word  : r_ram_addr;
   assign ram_wdata_o = w_ram_go ? w_sel.wdata : r_ram_wdata;
   assign ram_wr_o    = w_ram_go ? w_sel.wstrb : 4'h0;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_ram_addr  <= '0;
         r_ram_wdata <= 32'h0;
      end else if (w_ram_go) begin
         r_ram_addr  <= w_sel_word;
         r_ram_wdata <= w_sel.wdata;
      end
   end

   tcm_rsp_slot u_slot0 (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .grant_i     (w_gnt0),
      .grant_wr_i  (|req0_wstrb_i),
      .grant_err_i (w_oor0),
      .rsp_ready_i (rsp0_ready_i),
      .ram_rdata_i (ram_rdata_i),
      .eligible_o  (w_elig0),
      .rsp_valid_o (rsp0_valid_o),
      .rsp_rdata_o (rsp0_rdata_o),
      .rsp_err_o   (rsp0_err_o)
   );

   tcm_rsp_slot u_slot1 (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .grant_i     (w_gnt1),
      .grant_wr_i  (|req1_wstrb_i),
      .grant_err_i (w_oor1),
      .rsp_ready_i (rsp1_ready_i),
      .ram_rdata_i (ram_rdata_i),
      .eligible_o  (w_elig1),
      .rsp_valid_o (rsp1_valid_o),
      .rsp_rdata_o (rsp1_rdata_o),
      .rsp_err_o   (rsp1_err_o)
   );

endmodule : tcm_port_arbiter

`default_nettype wire
